id_bundle_queue: RTL

Decode-side producer of the instruction-feed handshake. Buffers decoded bundles (up to three 20-bit uops plus a 16-bit immediate) in a small FIFO and hands them, one bundle per transfer, to the reservation station through `id_feed_req` / `id_feed_ack`. It decouples decoder throughput from station consumption and provides a single-cycle flush for redirects.

---
 rtl/id_bundle_queue_pkg.sv | 17 +
 rtl/id_bundle_queue_mem.sv | 33 +++
 rtl/id_bundle_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/id_bundle_queue_pkg.sv
// Shared decode/station definitions: uop and immediate widths, bundle layout and the NOP uop.
package id_bundle_queue_pkg;

  localparam int UOP_W      = 20;
  localparam int K_W        = 16;
  localparam int UOP_SLOTS  = 3;
  localparam int UOP_CNT_W  = 2;

  // Decodes as a harmless no-op in the station; presented whenever the queue is empty.
  localparam logic [UOP_W-1:0] NOP_UOP = 20'b0000_0000_1111_00_000_000;

  // Packed bundle width: three uops, the valid-uop count and the immediate.
  function automatic int bundle_w(input int uop_w, input int k_w);
    return UOP_SLOTS * uop_w + UOP_CNT_W + k_w;
  endfunction

endpackage

// File: rtl/id_bundle_queue_mem.sv
// Bundle storage: DEPTH registers, one synchronous write port and one asynchronous read port.
module uop_bundle_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 78,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_slot [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          r_slot[gi] <= '0;
        end else if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
          r_slot[gi] <= i_wr_data;
        end
      end
    end
  endgenerate

  assign o_rd_data = r_slot[i_rd_addr];

endmodule

// File: rtl/id_bundle_queue.sv
// Decode-side bundle FIFO feeding the reservation station over the id_feed_req/id_feed_ack handshake.
module id_bundle_queue #(
  parameter int DEPTH = 4,
  parameter int UOP_W = id_bundle_queue_pkg::UOP_W,
  parameter int K_W   = id_bundle_queue_pkg::K_W
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic                         flush,
  input  logic                         dec_valid,
  output logic                         dec_ready,
  input  logic [UOP_W-1:0]             dec_uop_0,
  input  logic [UOP_W-1:0]             dec_uop_1,
  input  logic [UOP_W-1:0]             dec_uop_2,
  input  logic [1:0]                   dec_uop_count,
  input  logic [K_W-1:0]               dec_k16,
  input  logic                         id_feed_req,
  output logic                         id_feed_ack,
  output logic [UOP_W-1:0]             id_uop_0,
  output logic [UOP_W-1:0]             id_uop_1,
  output logic [UOP_W-1:0]             id_uop_2,
  output logic [1:0]                   id_uop_count,
  output logic [K_W-1:0]               id_k16,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  import id_bundle_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int BW    = bundle_w(UOP_W, K_W);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [UOP_W-1:0] NOP_W    = UOP_W'(NOP_UOP);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [BW-1:0]    w_wr_data;
  logic [BW-1:0]    w_rd_data;
  logic [UOP_W-1:0] w_rd_uop_0;
  logic [UOP_W-1:0] w_rd_uop_1;
  logic [UOP_W-1:0] w_rd_uop_2;
  logic [1:0]       w_rd_count;
  logic [K_W-1:0]   w_rd_k16;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Ready is a function of stored state only, so the station never reaches the decoder combinationally.
  assign dec_ready   = ~w_full;
  assign w_push      = dec_valid & dec_ready & ~flush & (dec_uop_count != 2'd0);
  assign w_pop       = id_feed_req & ~w_empty & ~flush;
  assign id_feed_ack = w_pop;
  assign occupancy   = r_count;

  assign w_wr_data = {dec_uop_2, dec_uop_1, dec_uop_0, dec_uop_count, dec_k16};
  assign {w_rd_uop_2, w_rd_uop_1, w_rd_uop_0, w_rd_count, w_rd_k16} = w_rd_data;

  uop_bundle_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (BW),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .a_rst     (a_rst),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale slot contents stay hidden behind NOP while the queue is empty.
  always_comb begin
    id_uop_0     = NOP_W;
    id_uop_1     = NOP_W;
    id_uop_2     = NOP_W;
    id_uop_count = 2'd0;
    id_k16       = '0;
    if (!w_empty) begin
      id_uop_0     = w_rd_uop_0;
      id_uop_1     = w_rd_uop_1;
      id_uop_2     = w_rd_uop_2;
      id_uop_count = w_rd_count;
      id_k16       = w_rd_k16;
    end
  end

endmodule
